// File: rtl/pipe_result_buffer_if.sv
// Bundles the issue/credit, pipeline-result and ready/valid output signals of
// pipe_result_buffer; slave is the buffer side, master the producer/consumer side.
interface pipe_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  issue_valid;
    logic                  issue_ready;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      credits;
    logic                  overflow;

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  res_valid,
        input  res_data,
        output out_valid,
        output out_data,
        input  out_ready,
        output occupancy,
        output credits,
        output overflow
    );

    modport master (
        output issue_valid,
        input  issue_ready,
        output res_valid,
        output res_data,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  occupancy,
        input  credits,
        input  overflow
    );
endinterface

// File: rtl/pipe_result_buffer.sv
// Credit-controlled result FIFO behind a valid-only pipeline: credits bound the
// in-flight work so every result finds a free slot, output is ready/valid.
module pipe_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_result_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_occ;
    logic [CNT_W-1:0]      r_credits;
    logic                  r_overflow;

    logic                  w_out_valid;
    logic                  w_issue_ready;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_drop;
    logic [CNT_W-1:0]      w_occ_d;
    logic [CNT_W-1:0]      w_credits_d;

    always_comb begin
        w_out_valid   = (r_occ != '0);
        w_issue_ready = (r_credits != '0);
        w_full        = (r_occ == DEPTH_C);
        w_pop         = w_out_valid & bus.out_ready;
        w_issue       = bus.issue_valid & w_issue_ready;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        w_push        = bus.res_valid & (~w_full | w_pop);
        w_drop        = bus.res_valid & w_full & ~w_pop;
        w_occ_d       = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
        w_credits_d   = r_credits - CNT_W'(w_issue) + CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_credits  <= DEPTH_C;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ     <= w_occ_d;
            r_credits <= w_credits_d;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; a result arriving during reset is not written.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= bus.res_data;
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.occupancy   = r_occ;
    assign bus.credits     = r_credits;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_pipe_result_buffer.sv
// Scoreboard bench for pipe_result_buffer: a latency-3 valid-only pipeline model
// feeds the buffer, expected results are queued at issue and checked at pop.
module tb_pipe_result_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    pipe_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    pipe_result_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] issue_data;
    logic          launch_en;
    logic          force_v;
    logic [DW-1:0] force_d;

    logic          pv0, pv1, pv2;
    logic [DW-1:0] pd0, pd1, pd2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream pipeline model, three stages, flushed by the same reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            pv0 <= 1'b0;
            pv1 <= 1'b0;
            pv2 <= 1'b0;
        end else begin
            pv0 <= bus.issue_valid & bus.issue_ready & launch_en;
            pv1 <= pv0;
            pv2 <= pv1;
        end
        pd0 <= issue_data;
        pd1 <= pd0;
        pd2 <= pd1;
    end

    assign bus.res_valid = pv2 | force_v;
    assign bus.res_data  = force_v ? force_d : pd2;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake on the output pops one expected value.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got 0x%0h expected no output at %0t",
                         bus.out_data, $time);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        if (rst_n) begin
            checks++;
            if (bus.credits > 3'(DEPTH)) begin
                errors++;
                $display("FAIL credit_bound: got %0d expected <= %0d", bus.credits, DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] d);
        chk("issue_ready_before_issue", 32'(bus.issue_ready), 32'd1);
        bus.issue_valid = 1'b1;
        issue_data      = d;
        exp_q.push_back(d);
        tick();
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        tick();
        for (int i = 0; i < n; i++) begin
            issue(base + DW'(i));
        end
        bus.issue_valid = 1'b0;
        tick();
        repeat (3) tick();
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        tick();
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        issue_data      = '0;
        launch_en       = 1'b1;
        force_v         = 1'b0;
        force_d         = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_credits",     32'(bus.credits),     32'd4);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_occupancy",   32'(bus.occupancy),   32'd0);
        chk("rst_overflow",    32'(bus.overflow),    32'd0);
        chk("rst_out_data",    bus.out_data,         32'd0);

        // Four back-to-back issues with the consumer stalled.
        tick();
        for (int i = 0; i < 4; i++) begin
            issue(32'h10 + DW'(i));
        end
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("fill_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("fill_credits0",    32'(bus.credits),     32'd0);
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("fill_occupancy", 32'(bus.occupancy), 32'd4);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
        chk("fill_head",      bus.out_data,       32'h10);
        chk("fill_credits",   32'(bus.credits),   32'd0);

        drain(4);
        chk("drain_occupancy", 32'(bus.occupancy), 32'd0);
        chk("drain_credits",   32'(bus.credits),   32'd4);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // Full FIFO with a result arriving in the same cycle as a pop.
        fill(32'h20, 4);
        chk("full2_occupancy", 32'(bus.occupancy), 32'd4);
        tick();
        bus.out_ready = 1'b1;
        force_v       = 1'b1;
        force_d       = 32'hAA;
        exp_q.push_back(32'hAA);
        tick();
        bus.out_ready = 1'b0;
        force_v       = 1'b0;
        @(negedge clk);
        chk("simul_occupancy", 32'(bus.occupancy), 32'd4);
        chk("simul_overflow",  32'(bus.overflow),  32'd0);
        chk("simul_credits",   32'(bus.credits),   32'd1);
        // Consume the credit the forced result would have used, without launching.
        tick();
        launch_en       = 1'b0;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        launch_en       = 1'b1;
        @(negedge clk);
        chk("sink_credits", 32'(bus.credits), 32'd0);
        drain(4);
        chk("drain2_occupancy", 32'(bus.occupancy), 32'd0);
        chk("drain2_credits",   32'(bus.credits),   32'd4);

        // Forced result into a full, stalled FIFO is dropped and flagged.
        fill(32'h30, 4);
        tick();
        force_v = 1'b1;
        force_d = 32'hBB;
        tick();
        force_v = 1'b0;
        @(negedge clk);
        chk("ovf_set",       32'(bus.overflow),  32'd1);
        chk("ovf_occupancy", 32'(bus.occupancy), 32'd4);
        chk("ovf_credits",   32'(bus.credits),   32'd0);
        chk("ovf_head",      bus.out_data,       32'h30);
        tick();
        repeat (2) tick();
        @(negedge clk);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        drain(4);
        chk("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
        chk("ovf_still_sticky",  32'(bus.overflow),  32'd1);
        chk("ovf_drain_credits", 32'(bus.credits),   32'd4);

        // Reset mid-operation with a result arriving in the reset cycle.
        fill(32'h40, 3);
        chk("pre_rst_occupancy", 32'(bus.occupancy), 32'd3);
        chk("pre_rst_credits",   32'(bus.credits),   32'd1);
        tick();
        rst_n   = 1'b0;
        force_v = 1'b1;
        force_d = 32'hCC;
        exp_q.delete();
        tick();
        rst_n   = 1'b1;
        force_v = 1'b0;
        @(negedge clk);
        chk("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("mid_rst_credits",   32'(bus.credits),   32'd4);
        chk("mid_rst_overflow",  32'(bus.overflow),  32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data",  bus.out_data,       32'd0);
        tick();
        repeat (2) tick();
        @(negedge clk);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
